// File: rtl/pwm_int_sched_pkg.sv
// Shared constants for the PWM/interrupt sequencer: register map,
// CTRL bit positions, FSM state encodings and default widths.
package pwm_int_pkg;

    localparam int N_CH_DEF   = 4;
    localparam int CNT_W_DEF  = 16;
    localparam int ADDR_W_DEF = 2;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PERIOD = 2'd1;
    localparam logic [1:0] REG_DUTY01 = 2'd2;
    localparam logic [1:0] REG_DUTY23 = 2'd3;

    localparam int CTRL_W     = 6;
    localparam int CTRL_RUN   = 4;
    localparam int CTRL_IRQEN = 5;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

endpackage

// File: rtl/pwm_int_sched_if.sv
// Register/PWM bundle of the sequencer. master = register-file side
// (write strobe, address, data, irq_ack); slave = the sequencer.
interface pwm_int_sched_if
    import pwm_int_pkg::*;
#(
    parameter int N_CH   = N_CH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              cfg_we;
    logic [ADDR_W-1:0] cfg_addr;
    logic [31:0]       cfg_wdata;
    logic [31:0]       cfg_rdata;
    logic              irq_ack;
    logic [N_CH-1:0]   pwm_out;
    logic              irq;
    logic              period_done;
    logic              busy;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, irq_ack,
        input  cfg_rdata, pwm_out, irq, period_done, busy
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, irq_ack,
        output cfg_rdata, pwm_out, irq, period_done, busy
    );
endinterface

// File: rtl/pwm_int_sched_chan.sv
// One PWM channel: compares the period count against the shadow duty.
// Ports: clock/reset, active (FSM busy), en, cnt, duty in; pwm out.
module pwm_int_chan
    import pwm_int_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             active,
    input  logic             en,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] duty,
    output logic             pwm
);
    logic pwm_q, pwm_d;

    always_comb begin
        pwm_d = active && en && (cnt < duty);
    end

    always_ff @(posedge clock) begin
        if (reset) pwm_q <= 1'b0;
        else       pwm_q <= pwm_d;
    end

    assign pwm = pwm_q;
endmodule

// File: rtl/pwm_int_sched.sv
// PWM/interrupt sequencer: active regs, shadow regs, period FSM, irq.
// Ports: clock, reset (sync, high); bus = pwm_int_sched_if.slave.
module pwm_int_sched
    import pwm_int_pkg::*;
#(
    parameter int N_CH   = N_CH_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input logic            clock,
    input logic            reset,
    pwm_int_sched_if.slave bus
);
    logic [CTRL_W-1:0]           ctrl_q, ctrl_d;
    logic [CNT_W-1:0]            period_q, period_d;
    logic [N_CH-1:0][CNT_W-1:0]  duty_q, duty_d;
    logic [N_CH-1:0]             sh_en_q, sh_en_d;
    logic                        sh_irqen_q, sh_irqen_d;
    logic [CNT_W-1:0]            sh_period_q, sh_period_d;
    logic [N_CH-1:0][CNT_W-1:0]  sh_duty_q, sh_duty_d;
    logic [1:0]                  state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        irq_q, irq_d;
    logic [31:0]                 rdata_q, rdata_d;
    logic                        run, last, active, load;
    logic [N_CH-1:0]             pwm_w;

    assign run    = ctrl_q[CTRL_RUN];
    assign active = (state_q != S_IDLE);
    assign last   = (cnt_q == sh_period_q);

    always_comb begin
        ctrl_d   = ctrl_q;
        period_d = period_q;
        duty_d   = duty_q;
        if (bus.cfg_we) begin
            case (bus.cfg_addr)
                REG_CTRL:   ctrl_d = bus.cfg_wdata[CTRL_W-1:0];
                REG_PERIOD: period_d = bus.cfg_wdata[CNT_W-1:0];
                REG_DUTY01: begin
                    duty_d[0] = bus.cfg_wdata[CNT_W-1:0];
                    duty_d[1] = bus.cfg_wdata[16 +: CNT_W];
                end
                REG_DUTY23: begin
                    duty_d[2] = bus.cfg_wdata[CNT_W-1:0];
                    duty_d[3] = bus.cfg_wdata[16 +: CNT_W];
                end
                default: ;
            endcase
        end
    end

    // Read-back uses the pre-write active values of this cycle.
    always_comb begin
        rdata_d = 32'd0;
        case (bus.cfg_addr)
            REG_CTRL:   rdata_d = 32'(ctrl_q);
            REG_PERIOD: rdata_d = 32'(period_q);
            REG_DUTY01: rdata_d = {16'(duty_q[1]), 16'(duty_q[0])};
            REG_DUTY23: rdata_d = {16'(duty_q[3]), 16'(duty_q[2])};
            default:    rdata_d = 32'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = last ? '0 : cnt_q + 1'b1;
        load    = last;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                load  = run;
                if (run) state_d = S_RUN;
            end
            S_RUN: begin
                if (!run) state_d = last ? S_IDLE : S_DRAIN;
            end
            S_DRAIN: begin
                if (run)       state_d = S_RUN;
                else if (last) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                load    = 1'b0;
            end
        endcase
    end

    // Shadow copy takes the pre-write register values, so a write on a
    // boundary edge waits for the following boundary.
    always_comb begin
        sh_en_d     = sh_en_q;
        sh_irqen_d  = sh_irqen_q;
        sh_period_d = sh_period_q;
        sh_duty_d   = sh_duty_q;
        if (load) begin
            sh_en_d     = ctrl_q[N_CH-1:0];
            sh_irqen_d  = ctrl_q[CTRL_IRQEN];
            sh_period_d = period_q;
            sh_duty_d   = duty_q;
        end
    end

    // Set beats a coincident acknowledge.
    always_comb begin
        irq_d = irq_q;
        if (active && last && sh_irqen_q) irq_d = 1'b1;
        else if (bus.irq_ack)             irq_d = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ctrl_q      <= '0;
            period_q    <= '0;
            duty_q      <= '0;
            sh_en_q     <= '0;
            sh_irqen_q  <= 1'b0;
            sh_period_q <= '0;
            sh_duty_q   <= '0;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            irq_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            ctrl_q      <= ctrl_d;
            period_q    <= period_d;
            duty_q      <= duty_d;
            sh_en_q     <= sh_en_d;
            sh_irqen_q  <= sh_irqen_d;
            sh_period_q <= sh_period_d;
            sh_duty_q   <= sh_duty_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            irq_q       <= irq_d;
            rdata_q     <= rdata_d;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        pwm_int_chan #(.CNT_W(CNT_W)) u_chan (
            .clock  (clock),
            .reset  (reset),
            .active (active),
            .en     (sh_en_q[i]),
            .cnt    (cnt_q),
            .duty   (sh_duty_q[i]),
            .pwm    (pwm_w[i])
        );
    end

    assign bus.pwm_out     = pwm_w;
    assign bus.irq         = irq_q;
    assign bus.period_done = active && last;
    assign bus.busy        = active;
    assign bus.cfg_rdata   = rdata_q;
endmodule

// File: doc/pwm_int_sched.md
Name: pwm_int_sched

Overview:
- Sequencing controller for the 4-channel PWM/interrupt peripheral.
- Sits between the AXI4-Lite register file and the PWM outputs; consumes the register-file write strobe and drives the register read-back.
- Holds the programmed period/duty configuration and double-buffers it into shadow registers at period boundaries, so outputs never glitch.
- Runs the period counter, generates 4 PWM waveforms, and raises a sticky period-end interrupt.

Parameters:
- N_CH, 4, number of PWM channels (fixed 4 in this release; register map assumes 4).
- CNT_W, 16, period/duty counter width.
- ADDR_W, 2, register word-address width (4 registers).

Ports:
- clock  in  1  system clock, all logic rising-edge.
- reset  in  1  synchronous, active-high; clears all state.
- cfg_we  in  1  single-cycle register write strobe.
- cfg_addr  in  ADDR_W  word address of write/read.
- cfg_wdata  in  32  write data.
- cfg_rdata  out  32  registered read-back of reg[cfg_addr], 1-cycle latency.
- irq_ack  in  1  pulse, clears irq.
- pwm_out  out  N_CH  PWM waveforms.
- irq  out  1  sticky interrupt, level.
- period_done  out  1  1-cycle pulse on last count of each period.
- busy  out  1  high in RUN or DRAIN.

Behaviour:
- Register map:
  - 0 CTRL: [3:0] channel enable, [4] global run, [5] irq enable.
  - 1 PERIOD: [CNT_W-1:0] P.
  - 2 DUTY01: {duty1[31:16], duty0[15:0]}.
  - 3 DUTY23: {duty3, duty2}.
  - Unused bits read 0.
- Reset values: all registers 0; pwm_out=0, irq=0, period_done=0, busy=0, cfg_rdata=0, cnt=0, state IDLE.
- Writes land in the active registers on the edge after cfg_we. Read-back shows the active (not shadow) values.
- State machine:
  - IDLE → RUN when CTRL[4]=1. On entry: cnt=0 and load shadow from active.
  - RUN → DRAIN when CTRL[4] is cleared; the current period completes.
  - DRAIN → IDLE on the last count. pwm_out=0 from the next cycle.
  - DRAIN → RUN if CTRL[4] is set again before the period ends.
- Counter: counts 0..P, so the period is P+1 cycles. At cnt==P: wrap to 0, pulse period_done, and reload shadow PERIOD/DUTY/enable.
- Shadow load samples the pre-write value if cfg_we hits the same edge. That write takes effect at the next boundary.
- pwm_out[i] (registered, 1-cycle after cnt):
  - High when shadow_en[i] && cnt < shadow_duty[i].
  - duty=0 → constant low.
  - duty>P → constant high.
  - P=0 → 1-cycle period: duty≥1 gives constant high; period_done high every cycle.
- irq: set at period_done when shadow irq-enable=1. Cleared by irq_ack. Simultaneous set and ack → set wins.
- In IDLE: cnt held at 0, outputs low, register writes still accepted.
- Reset mid-period: everything returns to reset values on the next edge, with no drain.

Decomposition:
- Package pwm_int_pkg:
  - Register address constants (REG_CTRL..REG_DUTY23).
  - CTRL bit indices.
  - State enum {IDLE, RUN, DRAIN}.
  - CNT_W default.
- Sub-module pwm_int_chan: one channel comparator plus output register, instantiated N_CH times.

Test Plan:
- Reset, then read all 4 regs → cfg_rdata=0 each, pwm_out=0, busy=0.
- PERIOD=9, DUTY01=0x0003_0005, CTRL=0x13 → pwm_out[0] high 5 of 10 cycles, pwm_out[1] high 3 of 10, ch2/3 low, period_done every 10 cycles.
- While running, write DUTY01 duty0=8 mid-period → current period keeps 5-high, next period 8-high; same-edge write at cnt==9 takes effect one period later.
- CTRL=0x33 → irq rises with first period_done. irq_ack in the same cycle as the next period_done → irq stays 1. Lone irq_ack → irq=0.
- Clear CTRL[4] at cnt=4 with P=9 → busy stays high until cnt 9, then IDLE, pwm_out=0. Re-set before cnt 9 → no gap.
- Edge cases:
  - duty0=0 → constant low.
  - duty0=12 with P=9 → constant high.
  - P=0, duty0=1 → constant high, period_done=1 every cycle.
  - reset asserted mid-period → all outputs 0 on the next edge.
